// File: rtl/sort8_frame_loader.sv
// sort8_frame_loader
//   Gathers a serial word stream into one eight-word frame for the sort8
//   combinational sorter. Short frames (in_last before the 8th word) are
//   padded with PAD_VALUE so the pads sort to the top. The frame is held on
//   x0..x7 with frame_valid until the consumer raises frame_ready.
// Ports
//   clk, rst              rising-edge clock, async active-high reset
//   in_valid/in_data/
//   in_last/in_ready      input stream handshake (accept = in_valid & in_ready)
//   x0..x7                frame slots, slot k = k-th accepted word
//   frame_valid/
//   frame_ready           frame handshake toward the sorter consumer
//   frame_len             real (non-pad) words in the held frame, 1..8
module sort8_frame_loader #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] PAD_VALUE = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] x0,
  output logic [WIDTH-1:0] x1,
  output logic [WIDTH-1:0] x2,
  output logic [WIDTH-1:0] x3,
  output logic [WIDTH-1:0] x4,
  output logic [WIDTH-1:0] x5,
  output logic [WIDTH-1:0] x6,
  output logic [WIDTH-1:0] x7,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic [3:0]       frame_len
);

  typedef enum logic [1:0] {S_FILL, S_PAD, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0]       len_q, len_d;
  logic [WIDTH-1:0] slot_q [8];
  logic [WIDTH-1:0] slot_d [8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FILL;
      idx_q   <= 3'd0;
      len_q   <= 4'd0;
      for (int k = 0; k < 8; k++) slot_q[k] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      for (int k = 0; k < 8; k++) slot_q[k] <= slot_d[k];
    end
  end

  // The "done" condition is the state itself: leaving FILL/PAD on slot 7
  // returns idx to 0 instead of letting the 3-bit counter wrap.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    for (int k = 0; k < 8; k++) slot_d[k] = slot_q[k];
    case (state_q)
      S_FILL: begin
        if (in_valid) begin
          slot_d[idx_q] = in_data;
          len_d         = {1'b0, idx_q} + 4'd1;
          if (idx_q == 3'd7) begin
            // Eighth word completes the frame; in_last is irrelevant here.
            state_d = S_HOLD;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
            if (in_last) state_d = S_PAD;
          end
        end
      end
      S_PAD: begin
        slot_d[idx_q] = PAD_VALUE;
        if (idx_q == 3'd7) begin
          state_d = S_HOLD;
          idx_d   = 3'd0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_HOLD: begin
        if (frame_ready) begin
          state_d = S_FILL;
          idx_d   = 3'd0;
        end
      end
      default: begin
        state_d = S_FILL;
        idx_d   = 3'd0;
      end
    endcase
  end

  // in_ready is held low while reset is asserted so no word looks accepted.
  assign in_ready    = (state_q == S_FILL) && !rst;
  assign frame_valid = (state_q == S_HOLD);
  assign frame_len   = len_q;

  assign x0 = slot_q[0];
  assign x1 = slot_q[1];
  assign x2 = slot_q[2];
  assign x3 = slot_q[3];
  assign x4 = slot_q[4];
  assign x5 = slot_q[5];
  assign x6 = slot_q[6];
  assign x7 = slot_q[7];

endmodule

// File: tb/tb_sort8_frame_loader.sv
module tb_sort8_frame_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [7:0] x0, x1, x2, x3, x4, x5, x6, x7;
  logic       frame_valid;
  logic       frame_ready = 1'b0;
  logic [3:0] frame_len;
  logic [7:0] xs [8];

  int errors = 0;
  int checks = 0;

  sort8_frame_loader #(.WIDTH(8), .PAD_VALUE(8'hFF)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6), .x7(x7),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_len(frame_len)
  );

  always #5 clk = ~clk;

  assign xs[0] = x0; assign xs[1] = x1; assign xs[2] = x2; assign xs[3] = x3;
  assign xs[4] = x4; assign xs[5] = x5; assign xs[6] = x6; assign xs[7] = x7;

  typedef struct {
    int              n;
    logic [0:7][7:0] w;
    logic            last;
    logic [0:7][7:0] ex;
    logic [3:0]      len;
    int              pad;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present one word from a negedge and return just after the accepting edge.
  task automatic send_word(input logic [7:0] d, input logic l);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!frame_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!frame_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic check_slots(input string tag, input logic [0:7][7:0] ex);
    for (int k = 0; k < 8; k++) chk($sformatf("%s_x%0d", tag, k), xs[k], ex[k]);
  endtask

  task automatic release_frame();
    @(negedge clk); frame_ready = 1'b1;
    @(posedge clk); #1; frame_ready = 1'b0;
    chk("release_fv", frame_valid, 0);
    chk("release_rdy", in_ready, 1);
  endtask

  initial begin
    int cnt;
    logic [0:7][7:0] f2a, f2b;

    vecs[0] = '{n: 8, w: {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, last: 1'b0,
                ex: {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, len: 4'd8, pad: 0};
    vecs[1] = '{n: 3, w: {8'd18, 8'd72, 8'd36, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, last: 1'b1,
                ex: {8'd18, 8'd72, 8'd36, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, len: 4'd3, pad: 5};
    vecs[2] = '{n: 1, w: {8'd42, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, last: 1'b1,
                ex: {8'd42, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, len: 4'd1, pad: 7};
    vecs[3] = '{n: 8, w: {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, last: 1'b1,
                ex: {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, len: 4'd8, pad: 0};

    // Reset state
    #3;
    chk("rst_fv", frame_valid, 0);
    chk("rst_len", frame_len, 0);
    chk("rst_rdy", in_ready, 0);
    check_slots("rst", '0);
    @(negedge clk); rst = 1'b0;
    #1 chk("post_rst_rdy", in_ready, 1);

    // Table-driven frames
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < vecs[t].n; i++)
        send_word(vecs[t].w[i], vecs[t].last && (i == vecs[t].n - 1));
      wait_valid(cnt);
      chk($sformatf("v%0d_pad", t), cnt, vecs[t].pad);
      check_slots($sformatf("v%0d", t), vecs[t].ex);
      chk($sformatf("v%0d_len", t), frame_len, vecs[t].len);
      chk($sformatf("v%0d_rdy", t), in_ready, 0);

      if (t == 0) begin
        // Backpressure: words offered while held must be ignored.
        @(negedge clk); in_valid = 1'b1; in_data = 8'd99;
        for (int c = 0; c < 10; c++) begin
          @(posedge clk); #1;
          chk("bp_rdy", in_ready, 0);
          chk("bp_fv", frame_valid, 1);
        end
        in_valid = 1'b0;
        check_slots("bp", vecs[0].ex);
        chk("bp_len", frame_len, 8);
      end
      release_frame();
    end

    // Back-to-back with frame_ready tied high
    f2a = {8'd5, 8'd6, 8'd7, 8'd8, 8'd1, 8'd2, 8'd3, 8'd4};
    f2b = {8'd80, 8'd86, 8'd56, 8'd1, 8'd52, 8'd12, 8'd20, 8'd17};
    frame_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_word(f2a[i], 1'b0);
    chk("b2b1_fv", frame_valid, 1);
    check_slots("b2b1", f2a);
    chk("b2b1_len", frame_len, 8);
    @(posedge clk); #1;
    chk("b2b1_fv_drop", frame_valid, 0);
    for (int i = 0; i < 8; i++) send_word(f2b[i], 1'b0);
    chk("b2b2_fv", frame_valid, 1);
    check_slots("b2b2", f2b);
    chk("b2b2_len", frame_len, 8);
    @(posedge clk); #1;
    chk("b2b2_fv_drop", frame_valid, 0);
    frame_ready = 1'b0;

    // frame_ready outside HOLD has no effect on an in-progress fill
    send_word(8'd11, 1'b0);
    @(negedge clk); frame_ready = 1'b1;
    @(posedge clk); #1; frame_ready = 1'b0;
    send_word(8'd22, 1'b1);
    wait_valid(cnt);
    chk("fr_ign_pad", cnt, 6);
    chk("fr_ign_x0", xs[0], 11);
    chk("fr_ign_x1", xs[1], 22);
    chk("fr_ign_len", frame_len, 2);
    release_frame();

    // Reset mid-fill, asserted between edges
    for (int i = 0; i < 4; i++) send_word(8'(30 + i), 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mrst_fv", frame_valid, 0);
    chk("mrst_len", frame_len, 0);
    check_slots("mrst", '0);
    @(negedge clk); rst = 1'b0;
    send_word(8'd77, 1'b0);
    send_word(8'd66, 1'b1);
    wait_valid(cnt);
    chk("mrst_pad", cnt, 6);
    check_slots("mrst_nf", {8'd77, 8'd66, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF});
    chk("mrst_nf_len", frame_len, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
